// File: rtl/axi_lite_sram_slave.sv
// axi_lite_sram_slave: AXI-lite responder backed by a word-addressed SRAM array.
//
// Read and write channels run independently, one outstanding transaction each.
// Responses are returned a fixed number of cycles after the request is captured.
//
// Ports:
//   clk_i, rst_ni              clock, synchronous active-low reset
//   araddr_i/arvalid_i/arready_o      read address channel
//   rdata_o/rresp_o/rvalid_o/rready_i read data channel (resp 00 OKAY, 10 SLVERR)
//   awaddr_i/awvalid_i/awready_o      write address channel
//   wdata_i/wstrb_i/wvalid_i/wready_o write data channel
//   bresp_o/bvalid_o/bready_i         write response channel
//
// Optional feature: define AXI_SRAM_RAND_DELAY_EN to add 0-3 pseudo-random extra cycles
// of latency per transaction (per-channel 4-bit LFSR, advanced on every handshake).
module axi_lite_sram_slave #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = 4,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE = 32'h8000_0000,
  parameter int unsigned MEM_WORDS  = 4096,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned WR_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] araddr_i,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  input  logic [ADDR_WIDTH-1:0] awaddr_i,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_WIDTH-1:0] wstrb_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  output logic [1:0]            bresp_o,
  output logic                  bvalid_o,
  input  logic                  bready_i
);

  localparam int unsigned IdxW = $clog2(MEM_WORDS);
  localparam int unsigned CntW = 8;
  localparam logic [ADDR_WIDTH-1:0] MemBytes = ADDR_WIDTH'(4 * MEM_WORDS);

  typedef enum logic [1:0] {RIdle, RWait, RResp} r_state_e;
  typedef enum logic [1:0] {WIdle, WWait, WResp} w_state_e;

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a >= MEM_BASE) && ((a - MEM_BASE) < MemBytes);
  endfunction

  function automatic logic [IdxW-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return IdxW'((a - MEM_BASE) >> 2);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  // Holds all readies low during reset and releases them one cycle after.
  logic rdy_q;

  r_state_e              r_state_q, r_state_d;
  logic [CntW-1:0]       r_cnt_q, r_cnt_d, r_load;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d, rd_addr;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  ar_fire, r_fire, r_enter;

  w_state_e              w_state_q, w_state_d;
  logic [CntW-1:0]       w_cnt_q, w_cnt_d, w_load;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d, wr_addr;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, wr_data;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d, wr_strb;
  logic [1:0]            bresp_q, bresp_d;
  logic                  aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic                  aw_fire, w_fire, b_fire, w_commit;

  assign arready_o = rdy_q && (r_state_q == RIdle);
  assign rvalid_o  = (r_state_q == RResp);
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;
  assign ar_fire   = arvalid_i && arready_o;
  assign r_fire    = rvalid_o && rready_i;

  assign awready_o = rdy_q && (w_state_q == WIdle) && !aw_got_q;
  assign wready_o  = rdy_q && (w_state_q == WIdle) && !w_got_q;
  assign bvalid_o  = (w_state_q == WResp);
  assign bresp_o   = bresp_q;
  assign aw_fire   = awvalid_i && awready_o;
  assign w_fire    = wvalid_i && wready_o;
  assign b_fire    = bvalid_o && bready_i;

`ifdef AXI_SRAM_RAND_DELAY_EN
  logic [3:0] r_lfsr_q, w_lfsr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_lfsr_q <= 4'b1001;
      w_lfsr_q <= 4'b1001;
    end else begin
      if (ar_fire || r_fire) r_lfsr_q <= {r_lfsr_q[2:0], r_lfsr_q[3] ^ r_lfsr_q[2]};
      if (aw_fire || w_fire || b_fire) w_lfsr_q <= {w_lfsr_q[2:0], w_lfsr_q[3] ^ w_lfsr_q[2]};
    end
  end

  assign r_load = CntW'(RD_LATENCY - 1) + CntW'(r_lfsr_q[1:0]);
  assign w_load = CntW'(WR_LATENCY - 1) + CntW'(w_lfsr_q[1:0]);
`else
  assign r_load = CntW'(RD_LATENCY - 1);
  assign w_load = CntW'(WR_LATENCY - 1);
`endif

  // Read channel next state; the response is sampled from the array on entry to RResp.
  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    ar_addr_d = ar_addr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rd_addr   = ar_addr_q;
    r_enter   = 1'b0;
    unique case (r_state_q)
      RIdle: begin
        if (ar_fire) begin
          ar_addr_d = araddr_i;
          rd_addr   = araddr_i;
          r_cnt_d   = r_load;
          if (r_load == '0) r_enter = 1'b1;
          else              r_state_d = RWait;
        end
      end
      RWait: begin
        r_cnt_d = r_cnt_q - CntW'(1);
        if (r_cnt_q == CntW'(1)) r_enter = 1'b1;
      end
      RResp: begin
        if (r_fire) r_state_d = RIdle;
      end
      default: r_state_d = RIdle;
    endcase
    if (r_enter) begin
      r_state_d = RResp;
      rdata_d   = addr_ok(rd_addr) ? mem_q[addr_idx(rd_addr)] : '0;
      rresp_d   = addr_ok(rd_addr) ? 2'b00 : 2'b10;
    end
  end

  // Write channel next state; AW and W are captured independently, the array is
  // written on entry to WResp.
  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    aw_addr_d = aw_addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    wr_addr   = aw_addr_q;
    wr_data   = wdata_q;
    wr_strb   = wstrb_q;
    w_commit  = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        if (aw_fire) begin
          aw_got_d  = 1'b1;
          aw_addr_d = awaddr_i;
          wr_addr   = awaddr_i;
        end
        if (w_fire) begin
          w_got_d = 1'b1;
          wdata_d = wdata_i;
          wstrb_d = wstrb_i;
          wr_data = wdata_i;
          wr_strb = wstrb_i;
        end
        // Only true on the edge where the second of the two halves arrives.
        if (aw_got_d && w_got_d) begin
          w_cnt_d = w_load;
          if (w_load == '0) w_commit = 1'b1;
          else              w_state_d = WWait;
        end
      end
      WWait: begin
        w_cnt_d = w_cnt_q - CntW'(1);
        if (w_cnt_q == CntW'(1)) w_commit = 1'b1;
      end
      WResp: begin
        if (b_fire) begin
          w_state_d = WIdle;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
        end
      end
      default: w_state_d = WIdle;
    endcase
    if (w_commit) begin
      w_state_d = WResp;
      bresp_d   = addr_ok(wr_addr) ? 2'b00 : 2'b10;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdy_q     <= 1'b0;
      r_state_q <= RIdle;
      r_cnt_q   <= '0;
      ar_addr_q <= '0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      w_state_q <= WIdle;
      w_cnt_q   <= '0;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= 2'b00;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
    end else begin
      rdy_q     <= 1'b1;
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      ar_addr_q <= ar_addr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      aw_addr_q <= aw_addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
    end
  end

  // Array is not reset; a reset edge suppresses any commit. A read sampled on the
  // same edge sees the old word because both updates are non-blocking.
  always_ff @(posedge clk_i) begin
    if (rst_ni && w_commit && addr_ok(wr_addr)) begin
      for (int k = 0; k < STRB_WIDTH; k++) begin
        if (wr_strb[k]) mem_q[addr_idx(wr_addr)][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

endmodule
